// File: rtl/uart_line_loader_pkg.sv
// Shared types and constants for the UART framebuffer line loader.
// State encodings, protocol characters and geometry defaults.
package uart_line_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW_HI,
    S_ROW_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WAIT_EOL,
    S_DROP
  } state_e;

  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam int ROWS_DEF   = 32;
  localparam int BPR_DEF    = 128;
  localparam int ADDR_W_DEF = 12;

endpackage

// File: rtl/uart_line_loader_hex.sv
// Combinational ASCII classifier: decimal digit, hex digit, nibble value.
// Shared by the row-number and data-byte states of the loader.
module ascii_hex_decode (
  input  logic [7:0] byte_in,
  output logic       is_hex,
  output logic       is_digit,
  output logic [3:0] nibble
);

  logic is_lc;
  logic is_uc;

  always_comb begin
    is_digit = (byte_in >= 8'h30) && (byte_in <= 8'h39);
    is_lc    = (byte_in >= 8'h61) && (byte_in <= 8'h66);
    is_uc    = (byte_in >= 8'h41) && (byte_in <= 8'h46);
    is_hex   = is_digit || is_lc || is_uc;
    // 'a'/'A' have low nibble 1, so +9 yields 10..15
    nibble   = is_digit ? byte_in[3:0] : byte_in[3:0] + 4'd9;
  end

endmodule

// File: rtl/uart_line_loader.sv
// Parses "L<rr><hex pairs>\n" lines from the UART byte stream
// into single-byte writes on framebuffer RAM port A.
module uart_line_loader
  import uart_line_loader_pkg::*;
#(
  parameter int ROWS          = ROWS_DEF,
  parameter int BYTES_PER_ROW = BPR_DEF,
  parameter int ADDR_WIDTH    = ADDR_W_DEF
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            ram_data_out,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_write_enable,
  output logic                  ram_clk_enable,
  output logic                  line_done,
  output logic                  line_error,
  output logic                  busy
);

  localparam int RW = $clog2(ROWS);
  localparam int BW = $clog2(BYTES_PER_ROW);
  localparam logic [BW-1:0] LAST_IDX = BW'(BYTES_PER_ROW - 1);

  state_e                state_q, state_d;
  logic [RW-1:0]         row_q, row_d;
  logic [BW-1:0]         idx_q, idx_d;
  logic [3:0]            hi_q, hi_d;
  logic [3:0]            nib_q, nib_d;
  logic [7:0]            data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic       is_hex;
  logic       is_digit;
  logic [3:0] nibble;
  logic [6:0] row_val;
  logic       take;

  ascii_hex_decode u_dec (
    .byte_in  (rx_data),
    .is_hex   (is_hex),
    .is_digit (is_digit),
    .nibble   (nibble)
  );

  assign row_val = {hi_q, 3'b000}
                 + {2'b00, hi_q, 1'b0}
                 + {3'b000, nibble};

  // CR is transparent everywhere except while discarding
  assign take = rx_valid
             && (state_q == S_DROP || rx_data != CH_CR);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    nib_d   = nib_q;
    data_d  = data_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (take) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data == CH_L) state_d = S_ROW_HI;
        end
        S_ROW_HI: begin
          if (is_digit) begin
            hi_d    = nibble;
            state_d = S_ROW_LO;
          end else begin
            err_d   = 1'b1;
            state_d = S_DROP;
          end
        end
        S_ROW_LO: begin
          if (is_digit && row_val < 7'(ROWS)) begin
            row_d   = row_val[RW-1:0];
            idx_d   = '0;
            state_d = S_DATA_HI;
          end else begin
            err_d   = 1'b1;
            state_d = S_DROP;
          end
        end
        S_DATA_HI: begin
          if (rx_data == CH_LF) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (is_hex) begin
            nib_d   = nibble;
            state_d = S_DATA_LO;
          end else begin
            err_d   = 1'b1;
            state_d = S_DROP;
          end
        end
        S_DATA_LO: begin
          if (is_hex) begin
            data_d  = {nib_q, nibble};
            addr_d  = ADDR_WIDTH'({row_q, idx_q});
            we_d    = 1'b1;
            idx_d   = idx_q + BW'(1);
            state_d = (idx_q == LAST_IDX)
                    ? S_WAIT_EOL : S_DATA_HI;
          end else begin
            err_d   = 1'b1;
            state_d = S_DROP;
          end
        end
        S_WAIT_EOL: begin
          if (rx_data == CH_LF) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_DROP;
          end
        end
        S_DROP: begin
          if (rx_data == CH_LF) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
      nib_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      nib_q   <= nib_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ram_data_out     = data_q;
  assign ram_address      = addr_q;
  assign ram_write_enable = we_q;
  assign ram_clk_enable   = we_q;
  assign line_done        = done_q;
  assign line_error       = err_q;
  assign busy             = (state_q != S_IDLE);

endmodule
